// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: shared AXI-Lite types for the VGA register path and the arbiter state encoding
package vga_axil_pkg;

   typedef logic [7:0]  axil_addr_t;
   typedef logic [31:0] axil_data_t;

   typedef enum logic [1:0] {
      AXIL_OKAY   = 2'b00,
      AXIL_EXOKAY = 2'b01,
      AXIL_SLVERR = 2'b10,
      AXIL_DECERR = 2'b11
   } axil_resp_e;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_WR_ADDR,
      ARB_WR_RESP,
      ARB_RD_ADDR,
      ARB_RD_RESP
   } axil_arb_state_e;

endpackage

// File: rtl/vga_rr_arbiter.sv
// vga_rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module vga_rr_arbiter #(
   parameter int N  = 2,
   parameter int GW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic [GW-1:0] grant,
   output logic          grant_valid
);

   logic [GW-1:0] idx;

   // scan from the farthest slot down to ptr so the nearest requester is written last and wins
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = GW'((int'(ptr) + k) % N);
         if (req[idx]) grant = idx;
      end
   end

   assign grant_valid = |req;

endmodule

// File: rtl/vga_axil_arbiter.sv
// vga_axil_arbiter: round-robin share of one AXI-Lite slave port among several masters, one transaction at a time
module vga_axil_arbiter
   import vga_axil_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic       [NUM_MASTERS-1:0] s_awvalid,
   output logic       [NUM_MASTERS-1:0] s_awready,
   input  axil_addr_t [NUM_MASTERS-1:0] s_awaddr,
   input  logic       [NUM_MASTERS-1:0] s_wvalid,
   output logic       [NUM_MASTERS-1:0] s_wready,
   input  axil_data_t [NUM_MASTERS-1:0] s_wdata,
   output logic       [NUM_MASTERS-1:0] s_bvalid,
   input  logic       [NUM_MASTERS-1:0] s_bready,
   output axil_resp_e [NUM_MASTERS-1:0] s_bresp,
   input  logic       [NUM_MASTERS-1:0] s_arvalid,
   output logic       [NUM_MASTERS-1:0] s_arready,
   input  axil_addr_t [NUM_MASTERS-1:0] s_araddr,
   output logic       [NUM_MASTERS-1:0] s_rvalid,
   input  logic       [NUM_MASTERS-1:0] s_rready,
   output axil_data_t [NUM_MASTERS-1:0] s_rdata,
   output axil_resp_e [NUM_MASTERS-1:0] s_rresp,
   output logic                         m_awvalid,
   input  logic                         m_awready,
   output axil_addr_t                   m_awaddr,
   output logic                         m_wvalid,
   input  logic                         m_wready,
   output axil_data_t                   m_wdata,
   input  logic                         m_bvalid,
   output logic                         m_bready,
   input  axil_resp_e                   m_bresp,
   output logic                         m_arvalid,
   input  logic                         m_arready,
   output axil_addr_t                   m_araddr,
   input  logic                         m_rvalid,
   output logic                         m_rready,
   input  axil_data_t                   m_rdata,
   input  axil_resp_e                   m_rresp,
   output logic [GW-1:0]                grant_o,
   output logic                         busy_o
);

   axil_arb_state_e        state, state_n;
   logic [GW-1:0]          rr_ptr, rr_ptr_n, grant_n, arb_grant, g_next;
   logic                   aw_done, aw_done_n, w_done, w_done_n, arb_valid;
   logic [NUM_MASTERS-1:0] wr_req;

   assign wr_req = s_awvalid & s_wvalid;
   assign g_next = (int'(grant_o) == NUM_MASTERS - 1) ? '0 : grant_o + 1'b1;
   assign busy_o = state != ARB_IDLE;

   vga_rr_arbiter #(.N(NUM_MASTERS), .GW(GW)) u_rr (
      .req         (wr_req | s_arvalid),
      .ptr         (rr_ptr),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   // state, owner and channel-done flags; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= ARB_IDLE;
         rr_ptr  <= '0;
         grant_o <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_n;
         rr_ptr  <= rr_ptr_n;
         grant_o <= grant_n;
         aw_done <= aw_done_n;
         w_done  <= w_done_n;
      end
   end

   // route the owner's channels to the slave and the response back to the owner only
   always_comb begin
      state_n   = state;
      rr_ptr_n  = rr_ptr;
      grant_n   = grant_o;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      m_awaddr  = s_awaddr[grant_o];
      m_wdata   = s_wdata[grant_o];
      m_araddr  = s_araddr[grant_o];
      s_awready = '0;
      s_wready  = '0;
      s_bvalid  = '0;
      s_arready = '0;
      s_rvalid  = '0;
      s_rdata   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         s_bresp[i] = AXIL_OKAY;
         s_rresp[i] = AXIL_OKAY;
      end
      case (state)
         ARB_IDLE: begin
            if (arb_valid) begin
               grant_n = arb_grant;
               state_n = wr_req[arb_grant] ? ARB_WR_ADDR : ARB_RD_ADDR;
            end
         end
         ARB_WR_ADDR: begin
            m_awvalid          = s_awvalid[grant_o] & ~aw_done;
            m_wvalid           = s_wvalid[grant_o] & ~w_done;
            s_awready[grant_o] = m_awready & ~aw_done;
            s_wready[grant_o]  = m_wready & ~w_done;
            aw_done_n          = aw_done | (m_awvalid & m_awready);
            w_done_n           = w_done | (m_wvalid & m_wready);
            if (aw_done_n & w_done_n) begin
               state_n   = ARB_WR_RESP;
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
            end
         end
         ARB_WR_RESP: begin
            s_bvalid[grant_o] = m_bvalid;
            s_bresp[grant_o]  = m_bresp;
            m_bready          = s_bready[grant_o];
            if (m_bvalid & m_bready) begin
               rr_ptr_n = g_next;
               state_n  = ARB_IDLE;
            end
         end
         ARB_RD_ADDR: begin
            m_arvalid          = s_arvalid[grant_o];
            s_arready[grant_o] = m_arready;
            if (m_arvalid & m_arready) state_n = ARB_RD_RESP;
         end
         ARB_RD_RESP: begin
            s_rvalid[grant_o] = m_rvalid;
            s_rdata[grant_o]  = m_rdata;
            s_rresp[grant_o]  = m_rresp;
            m_rready          = s_rready[grant_o];
            if (m_rvalid & m_rready) begin
               rr_ptr_n = g_next;
               state_n  = ARB_IDLE;
            end
         end
         default: state_n = ARB_IDLE;
      endcase
   end

endmodule
